frame_buffer_scheduler: RTL
===========================

// Module: frame_buffer_scheduler
// PURPOSE
//  Triple-buffer bank scheduler for the camera-to-HDMI frame store. The BRAM holds 3 frame banks;
//  this block decides which bank the camera capture writes and which bank the video timing generator reads,
//  publishing completed frames at display frame boundaries so the display never shows a torn frame.
//  Runs in the 25 MHz pixel domain; camera-side pulses arrive pre-synchronized as 1-cycle pulses.
// PARAMETERS
//  FRAME_PIXELS  76800  pixels per bank (320x240); bank k base address = k*FRAME_PIXELS
//  ADDR_W        18     BRAM address width (must hold 3*FRAME_PIXELS-1)
//  CNT_W         16     width of saturating status counters
// PORTS
//  clk            in   1       pixel clock (25 MHz), all logic on rising edge
//  rst            in   1       synchronous, active-high reset
//  enable         in   1       1 = capture allowed; 0 = writer parked
//  wr_frame_start in   1       1-cycle pulse, camera VSYNC-derived start of frame
//  wr_frame_done  in   1       1-cycle pulse, camera wrote last pixel of frame
//  rd_frame_start in   1       1-cycle pulse, display start of frame (before first active line)
//  wr_active      out  1       camera writes permitted (gate for BRAM port A we)
//  wr_base_addr   out  ADDR_W  base address of write bank
//  rd_base_addr   out  ADDR_W  base address of read bank
//  rd_valid       out  1       read bank holds a complete frame (0 -> display shows background)
//  drop_cnt       out  CNT_W   completed frames overwritten before display
//  repeat_cnt     out  CNT_W   display frames that re-showed the previous bank
//  trunc_cnt      out  CNT_W   capture frames aborted (restart, disable) before done
// BEHAVIOUR
//  Reset: wr_bank=0, rd_bank=1, lat_bank=2, lat_valid=0, rd_valid=0, wr_active=0, all counters 0,
//   wr_base_addr=0, rd_base_addr=FRAME_PIXELS, FSM=IDLE. Banks W,R,L always mutually distinct.
//  Writer FSM (IDLE, WAIT_SOF, CAPTURE):
//   IDLE: enable=1 -> WAIT_SOF.
//   WAIT_SOF: wr_frame_start -> CAPTURE; wr_frame_done ignored (partial frame after enable).
//   CAPTURE: wr_frame_done -> publish (below), -> WAIT_SOF; wr_frame_start without done -> trunc_cnt++,
//    stay CAPTURE, same bank reused, nothing published.
//   Any state: enable=0 -> IDLE; from CAPTURE counts trunc_cnt++; bank assignment retained.
//   wr_active = (FSM==CAPTURE), registered: high cycle after wr_frame_start, low cycle after done/abort.
//  Publish (wr_frame_done in CAPTURE, no rd_frame_start same cycle):
//   lat_valid=0: L<=W, W<=free bank (not R, not W), lat_valid<=1.
//   lat_valid=1: drop_cnt++, swap W<->L (old latest discarded), lat_valid stays 1.
//  Display switch (rd_frame_start, no publish same cycle):
//   lat_valid=1: R<=L, L<=old R, lat_valid<=0, rd_valid<=1.
//   lat_valid=0: R unchanged, repeat_cnt++ only if rd_valid=1.
//  Simultaneous publish + rd_frame_start: just-completed frame is shown directly: R<=old W;
//   lat_valid=0: W<=free bank; lat_valid=1: W<=old L, drop_cnt++; lat_valid<=0; rd_valid<=1.
//  wr_frame_start and wr_frame_done same cycle in CAPTURE: done wins (publish), FSM -> CAPTURE
//   for the new frame (no trunc).
//  Latency: bank indices update 1 cycle after pulse; base addresses registered, valid 2 cycles after pulse.
//   rd_frame_start precedes first active pixel by >=1 line, so read-address change is never mid-frame.
//  Base address = constant-mux of {0, FRAME_PIXELS, 2*FRAME_PIXELS}; no multiplier.
//  Counters saturate at 2^CNT_W-1; cleared only by rst.
//  rst asserted mid-frame: full reset values next cycle; in-flight frame discarded.
// STRUCTURE
//  Package fb_pkg: BANK_W=2, bank ids 0..2, FRAME_PIXELS, writer FSM state enum, free_bank(a,b) function.
//  One sub-module: sat_counter (CNT_W, inc, rst) instanced x3. Rest is flat single always block + FSM.
// TESTING
//  1 Reset, enable=1, start@10, done@100, rd_frame_start@200 -> at 202 rd_base_addr=0, rd_valid=1,
//    wr_base_addr=2*FRAME_PIXELS; no counter changes.
//  2 Two start/done pairs with no rd_frame_start, then rd_frame_start -> drop_cnt=1, shown bank = second frame.
//  3 rd_frame_start x3 with no new capture after valid frame -> repeat_cnt=3, rd_base_addr unchanged.
//  4 wr_frame_done and rd_frame_start same cycle (lat_valid=0 and =1 cases) -> R=old W, W/R/L distinct,
//    drop_cnt increments only in lat_valid=1 case.
//  5 done before any start after enable -> ignored; start,start,done -> trunc_cnt=1, one frame published;
//    enable=0 mid-capture -> wr_active=0 next cycle, trunc_cnt++.
//  6 Random pulse soak 1e6 cycles: assert W,R,L distinct every cycle, rd_base_addr changes only on
//    cycle+2 after rd_frame_start, counters saturate (CNT_W=4 build) at 15.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the triple-buffer frame bank scheduler.
// Bank ids are 0..2. The writer, reader and latest banks are always a permutation of them.
package fb_pkg;

    localparam int BANK_W          = 2;
    localparam int FB_FRAME_PIXELS = 76800;

    typedef logic [BANK_W-1:0] bank_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_CAPTURE  = 2'd2
    } wr_state_e;

    // Internal bank bookkeeping, exposed so checkers can bind to it.
    typedef struct packed {
        wr_state_e state;
        bank_t     wr_bank;
        bank_t     rd_bank;
        bank_t     lat_bank;
        logic      lat_valid;
    } fb_dbg_t;

    // Returns the one bank id that is neither a nor b (a != b assumed).
    function automatic bank_t free_bank(input bank_t a, input bank_t b);
        if (a != 2'd0 && b != 2'd0) begin
            return 2'd0;
        end else if (a != 2'd1 && b != 2'd1) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones, cleared only by synchronous reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer bank scheduler: camera writes bank W, display reads bank R, bank L holds the
// newest completed frame until the next display frame boundary picks it up.
module frame_buffer_scheduler
    import fb_pkg::*;
#(
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS,
    parameter int ADDR_W       = 18,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    input  logic              rd_frame_start,
    output logic              wr_active,
    output logic [ADDR_W-1:0] wr_base_addr,
    output logic [ADDR_W-1:0] rd_base_addr,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt,
    output logic [CNT_W-1:0]  trunc_cnt,
    output fb_dbg_t           dbg
);

    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(2 * FRAME_PIXELS);

    function automatic logic [ADDR_W-1:0] bank_base(input bank_t b);
        case (b)
            2'd1:    return BASE1;
            2'd2:    return BASE2;
            default: return '0;
        endcase
    endfunction

    wr_state_e         state_q, state_d;
    bank_t             wr_bank_q, wr_bank_d;
    bank_t             rd_bank_q, rd_bank_d;
    bank_t             lat_bank_q, lat_bank_d;
    logic              lat_valid_q, lat_valid_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_active_q;
    logic [ADDR_W-1:0] wr_base_q, rd_base_q;
    logic              publish, abort, drop_inc, repeat_inc;

    // Writer FSM. Deasserting enable wins over any pulse in the same cycle.
    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        abort   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            abort   = (state_q == ST_CAPTURE);
        end else begin
            case (state_q)
                ST_IDLE:     state_d = ST_WAIT_SOF;
                ST_WAIT_SOF: if (wr_frame_start) state_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (wr_frame_done) begin
                        publish = 1'b1;
                        if (!wr_frame_start) state_d = ST_WAIT_SOF;
                    end else if (wr_frame_start) begin
                        abort = 1'b1;
                    end
                end
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Bank rotation. Every branch permutes W/R/L, so the three stay distinct.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        lat_bank_d  = lat_bank_q;
        lat_valid_d = lat_valid_q;
        rd_valid_d  = rd_valid_q;
        drop_inc    = 1'b0;
        repeat_inc  = 1'b0;
        if (publish && rd_frame_start) begin
            rd_bank_d   = wr_bank_q;
            wr_bank_d   = lat_valid_q ? lat_bank_q : free_bank(rd_bank_q, wr_bank_q);
            lat_bank_d  = rd_bank_q;
            lat_valid_d = 1'b0;
            rd_valid_d  = 1'b1;
            drop_inc    = lat_valid_q;
        end else if (publish) begin
            lat_bank_d  = wr_bank_q;
            wr_bank_d   = lat_valid_q ? lat_bank_q : free_bank(rd_bank_q, wr_bank_q);
            lat_valid_d = 1'b1;
            drop_inc    = lat_valid_q;
        end else if (rd_frame_start) begin
            if (lat_valid_q) begin
                rd_bank_d   = lat_bank_q;
                lat_bank_d  = rd_bank_q;
                lat_valid_d = 1'b0;
                rd_valid_d  = 1'b1;
            end else begin
                repeat_inc  = rd_valid_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_bank_q   <= 2'd0;
            rd_bank_q   <= 2'd1;
            lat_bank_q  <= 2'd2;
            lat_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_active_q <= 1'b0;
            wr_base_q   <= '0;
            rd_base_q   <= BASE1;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            lat_bank_q  <= lat_bank_d;
            lat_valid_q <= lat_valid_d;
            rd_valid_q  <= rd_valid_d;
            wr_active_q <= (state_d == ST_CAPTURE);
            // Addresses trail the bank indices by one cycle.
            wr_base_q   <= bank_base(wr_bank_q);
            rd_base_q   <= bank_base(rd_bank_q);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk_i(clk), .rst_i(rst), .inc_i(drop_inc), .count_o(drop_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_repeat_cnt (
        .clk_i(clk), .rst_i(rst), .inc_i(repeat_inc), .count_o(repeat_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_trunc_cnt (
        .clk_i(clk), .rst_i(rst), .inc_i(abort), .count_o(trunc_cnt)
    );

    assign wr_active     = wr_active_q;
    assign wr_base_addr  = wr_base_q;
    assign rd_base_addr  = rd_base_q;
    assign rd_valid      = rd_valid_q;
    assign dbg.state     = state_q;
    assign dbg.wr_bank   = wr_bank_q;
    assign dbg.rd_bank   = rd_bank_q;
    assign dbg.lat_bank  = lat_bank_q;
    assign dbg.lat_valid = lat_valid_q;

endmodule
